// File: rtl/regfile_port_master_pkg.sv
// Shared definitions for the register-file port sequencer.
package regfile_port_master_pkg;

    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 0;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

endpackage

// File: rtl/regfile_port_master.sv
// Sequencing master for the 32x32 three-port register file of the multi-cycle
// MIPS datapath. It clears r1..r31 after reset, reads both operands of each
// instruction, holds them for the ALU, and then performs the one-cycle writeback.
module regfile_port_master
    import regfile_port_master_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic              wb_en,
    output logic [DATA_W-1:0] opA,
    output logic [DATA_W-1:0] opB,
    output logic              ops_valid,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              done,
    output logic [ADDR_W-1:0] Ard1,
    output logic [ADDR_W-1:0] Ard2,
    output logic [ADDR_W-1:0] Awr,
    output logic [DATA_W-1:0] Din,
    output logic              WrEn,
    input  logic [DATA_W-1:0] Dout1,
    input  logic [DATA_W-1:0] Dout2
);

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(ZERO_REG);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] rs_q, rt_q, rd_q, awr_q;
    logic              wb_en_q;

    // Read addresses come straight from the latched request; the register
    // file reads combinationally, so they must be stable through READ and EXEC.
    assign Ard1 = rs_q;
    assign Ard2 = rt_q;

    // Next-state and per-state port strobes.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        ops_valid = 1'b0;
        done      = 1'b0;
        WrEn      = 1'b0;
        Awr       = awr_q;
        case (state)
            ST_INIT: begin
                // Din is held at zero by reset for the whole walk.
                WrEn = 1'b1;
                Awr  = cnt;
                if (cnt == LAST_REG) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_READ;
            end
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: begin
                ops_valid = 1'b1;
                if (res_valid) state_nxt = ST_WB;
            end
            ST_WB: begin
                // r0 is architecturally zero: never let a write reach it.
                done      = 1'b1;
                WrEn      = wb_en_q && (rd_q != ZERO_A);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = INIT_ON_RESET ? ST_INIT : ST_IDLE;
        endcase
    end

    // State, init counter and the request/operand/result latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
            cnt     <= ADDR_W'(1);
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            wb_en_q <= 1'b0;
            awr_q   <= '0;
            opA     <= '0;
            opB     <= '0;
            Din     <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) cnt <= cnt + 1'b1;
            if (state == ST_IDLE && req_valid) begin
                rs_q    <= rs;
                rt_q    <= rt;
                rd_q    <= rd;
                wb_en_q <= wb_en;
            end
            if (state == ST_READ) begin
                opA <= Dout1;
                opB <= Dout2;
            end
            if (state == ST_EXEC && res_valid) begin
                Din   <= res_data;
                awr_q <= rd_q;
            end
        end
    end

endmodule
